// File: rtl/ysyx_23060236_clint_mh.sv
// Multi-hart CLINT: prescaled mtime, per-hart mtimecmp/mtip and msip, AXI4-Lite-style MMIO port.
// Define YSYX_CLINT_MTIME_WR_EN to make mtime writable; otherwise mtime is read-only.
module ysyx_23060236_clint_mh #(
    parameter int unsigned NHART    = 1,
    parameter int unsigned MTIME_W  = 64,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      araddr,
    input  logic             arvalid,
    output logic             arready,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rvalid,
    input  logic             rready,
    input  logic [31:0]      awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wvalid,
    output logic             wready,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    output logic [NHART-1:0] msip,
    output logic [NHART-1:0] mtip
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic { R_IDLE, R_RESP } rstate_t;
    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic [1:0] { A_NONE, A_MSIP, A_CMP, A_MTIME } akind_t;
    typedef struct packed {
        akind_t      kind;
        logic [11:0] idx;
        logic        hi;
    } adec_t;

    // a is byte address bits [15:2]
    function automatic adec_t decode(input logic [13:0] a);
        adec_t d;
        d.kind = A_NONE;
        d.idx  = '0;
        d.hi   = 1'b0;
        if (a[13:12] == 2'b00 && {20'b0, a[11:0]} < NHART) begin
            d.kind = A_MSIP;
            d.idx  = a[11:0];
        end else if (a[13:12] == 2'b01 && {21'b0, a[11:1]} < NHART) begin
            d.kind = A_CMP;
            d.idx  = {1'b0, a[11:1]};
            d.hi   = a[0];
        end else if (a[13:1] == 13'h17FF) begin
            d.kind = A_MTIME;
            d.hi   = a[0];
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    rstate_t            r_state, r_next;
    wstate_t            w_state, w_next;
    logic [MTIME_W-1:0] mtime_q;
    logic [MTIME_W-1:0] cmp_q [NHART];
    logic [NHART-1:0]   msip_q, mtip_q;
    logic [PW-1:0]      ps_cnt;
    logic               tick, rd_fire, wr_fire, wr_ok, rd_err;
    adec_t              rd_dec, wr_dec;
    logic [63:0]        rd_wide, wr_old, wr_merged;
    logic [31:0]        rd_word, rdata_q;
    logic [1:0]         rresp_q, bresp_q;
    logic [MTIME_W-1:0] wr_val;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{araddr[31:16], araddr[1:0], awaddr[31:16], awaddr[1:0]};

    assign tick    = (ps_cnt == PS_LAST);
    assign rd_fire = (r_state == R_IDLE) && arvalid;
    assign wr_fire = (w_state == W_IDLE) && awvalid && wvalid;
    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign awready = wr_fire;
    assign wready  = wr_fire;
    assign bvalid  = (w_state == W_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign bresp   = bresp_q;
    assign msip    = msip_q;
    assign mtip    = mtip_q;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (arvalid) r_next = R_RESP;
            R_RESP: if (rready)  r_next = R_IDLE;
        endcase
        w_next = w_state;
        case (w_state)
            W_IDLE: if (awvalid && wvalid) w_next = W_RESP;
            W_RESP: if (bready)            w_next = W_IDLE;
        endcase
    end

    // Every register is viewed as a zero-extended 64-bit pair of words so hi reads of narrow mtime give 0.
    always_comb begin
        rd_dec  = decode(araddr[15:2]);
        rd_wide = '0;
        rd_err  = 1'b0;
        case (rd_dec.kind)
            A_MSIP: begin
                for (int unsigned h = 0; h < NHART; h++)
                    if (32'(rd_dec.idx) == h) rd_wide = {63'b0, msip_q[h]};
            end
            A_CMP: begin
                for (int unsigned h = 0; h < NHART; h++)
                    if (32'(rd_dec.idx) == h) rd_wide = 64'(cmp_q[h]);
            end
            A_MTIME: rd_wide = 64'(mtime_q);
            default: rd_err = 1'b1;
        endcase
        rd_word = rd_dec.hi ? rd_wide[63:32] : rd_wide[31:0];
    end

    always_comb begin
        wr_dec = decode(awaddr[15:2]);
        wr_old = '0;
        if (wr_dec.kind == A_CMP) begin
            for (int unsigned h = 0; h < NHART; h++)
                if (32'(wr_dec.idx) == h) wr_old = 64'(cmp_q[h]);
        end else if (wr_dec.kind == A_MTIME) begin
            wr_old = 64'(mtime_q);
        end
        wr_merged = wr_old;
        if (wr_dec.hi) wr_merged[63:32] = merge(wr_old[63:32], wdata, wstrb);
        else           wr_merged[31:0]  = merge(wr_old[31:0], wdata, wstrb);
        wr_val = wr_merged[MTIME_W-1:0];
`ifdef YSYX_CLINT_MTIME_WR_EN
        wr_ok = (wr_dec.kind != A_NONE);
`else
        wr_ok = (wr_dec.kind == A_MSIP) || (wr_dec.kind == A_CMP);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            rdata_q <= '0;
            rresp_q <= '0;
            bresp_q <= '0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (rd_fire) begin
                rdata_q <= rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
            if (wr_fire) bresp_q <= wr_ok ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_cnt  <= '0;
            mtime_q <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            for (int unsigned h = 0; h < NHART; h++) cmp_q[h] <= '1;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + PW'(1);
`ifdef YSYX_CLINT_MTIME_WR_EN
            if (wr_fire && wr_dec.kind == A_MTIME) mtime_q <= wr_val;
            else
`endif
            if (tick) mtime_q <= mtime_q + MTIME_W'(1);
            for (int unsigned h = 0; h < NHART; h++) begin
                if (wr_fire && wr_dec.kind == A_MSIP && 32'(wr_dec.idx) == h && wstrb[0])
                    msip_q[h] <= wdata[0];
                if (wr_fire && wr_dec.kind == A_CMP && 32'(wr_dec.idx) == h)
                    cmp_q[h] <= wr_val;
                mtip_q[h] <= (mtime_q >= cmp_q[h]);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_clint_mh.sv
// Bench for the CLINT (NHART=2, PRESCALE=4): directed steps plus random bus traffic against a register model.
module tb_ysyx_23060236_clint_mh;

    localparam int unsigned NH = 2;
    localparam int unsigned P  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   araddr = '0, awaddr = '0, wdata = '0;
    logic          arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [3:0]    wstrb = '0;
    logic          arready, rvalid, awready, wready, bvalid;
    logic [31:0]   rdata;
    logic [1:0]    rresp, bresp;
    logic [NH-1:0] msip, mtip;

    ysyx_23060236_clint_mh #(.NHART(NH), .MTIME_W(64), .PRESCALE(P)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .msip(msip), .mtip(mtip)
    );

    always #5 clock = ~clock;

    // clock edges seen since reset release; mtime after edge k is k/P
    int unsigned cyc;
    always @(posedge clock or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;

    function automatic logic [63:0] mtime_at(input int unsigned k);
        return 64'(k / P);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int unsigned acc);
        @(negedge clock);
        check("arready_idle", 64'(arready), 64'd1);
        araddr = a; arvalid = 1'b1; acc = cyc;
        @(posedge clock); #1;
        arvalid = 1'b0;
        check("rvalid_lat1", 64'(rvalid), 64'd1);
        d = rdata; r = rresp;
        @(posedge clock); #1;
        check("rdata_hold", 64'(rdata), 64'(d));
        rready = 1'b1;
        @(posedge clock); #1;
        rready = 1'b0;
        check("rvalid_drop", 64'(rvalid), 64'd0);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] b, output int unsigned acc);
        @(negedge clock);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; acc = cyc;
        #1;
        check("aw_w_ready", 64'({awready, wready}), 64'd3);
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_lat1", 64'(bvalid), 64'd1);
        b = bresp;
        @(posedge clock); #1;
        check("bvalid_hold", 64'(bvalid), 64'd1);
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
        check("bvalid_drop", 64'(bvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a, wd, half, exp_d;
        logic [15:0] a16;
        logic [1:0]  r, b, exp_resp;
        logic [3:0]  ws;
        logic [NH-1:0] exp_mtip;
        logic        is_wr;
        int unsigned acc, e_cmp, k;
        logic [31:0] pool [16];
        pool = '{32'h0000, 32'h0004, 32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'hBFF8, 32'hBFFC,
                 32'h0008, 32'h0010, 32'h4010, 32'h4018, 32'h8000, 32'hBFF4, 32'hC000, 32'h1234_4008};

        // reset state
        #1 reset = 1'b0;
        #2;
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_resp",    64'({rresp, bresp}), 64'd0);
        check("rst_msip",    64'(msip),    64'd0);
        check("rst_mtip",    64'(mtip),    64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        m_msip = '0;

        // prescaled mtime after 40 cycles
        repeat (40) @(posedge clock);
        bus_rd(32'hBFF8, d, r, acc);
        check("mtime40_lo", 64'(d), mtime_at(acc) & 64'hFFFF_FFFF);
        check("mtime40_range", 64'(d >= 9 && d <= 11), 64'd1);
        check("mtime40_rresp", 64'(r), 64'd0);
        bus_rd(32'hBFFC, d, r, acc);
        check("mtime40_hi", 64'(d), mtime_at(acc) >> 32);

        // hart 1 compare at 20
        bus_wr(32'h4008, 32'd20, 4'hF, b, acc);
        check("cmp1_lo_bresp", 64'(b), 64'd0);
        bus_wr(32'h400C, 32'd0, 4'hF, b, acc);
        check("cmp1_hi_bresp", 64'(b), 64'd0);
        e_cmp = acc + 1;
        m_cmp[1] = 64'd20;
        for (int j = 0; j < 70; j++) begin
            @(negedge clock);
            k = cyc;
            exp_mtip = {(k - 1 >= e_cmp) && (mtime_at(k - 1) >= 64'd20), 1'b0};
            check("mtip_cmp20", 64'(mtip), 64'(exp_mtip));
        end

        // msip lanes
        bus_wr(32'h0004, 32'hFFFF_FFFF, 4'b0001, b, acc);
        check("msip1_bresp", 64'(b), 64'd0);
        m_msip[1] = 1'b1;
        check("msip_set", 64'(msip), 64'(m_msip));
        bus_wr(32'h0000, 32'hFFFF_FFFF, 4'b1110, b, acc);
        check("msip_nolane", 64'(msip), 64'(m_msip));
        bus_rd(32'h0004, d, r, acc);
        check("msip1_rd", 64'(d), 64'd1);
        check("msip1_rresp", 64'(r), 64'd0);
        bus_rd(32'h0000, d, r, acc);
        check("msip0_rd", 64'(d), 64'd0);

        // unmapped and out-of-range harts
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 32'h0008 : (i == 1) ? 32'h8000 : 32'h4010;
            bus_wr(a, 32'hFFFF_FFFF, 4'hF, b, acc);
            check("unmapped_bresp", 64'(b), 64'd2);
            bus_rd(a, d, r, acc);
            check("unmapped_rdata", 64'(d), 64'd0);
            check("unmapped_rresp", 64'(r), 64'd2);
        end
        check("unmapped_msip", 64'(msip), 64'(m_msip));
        bus_rd(32'h4008, d, r, acc);
        check("cmp1_intact", 64'(d), 64'd20);

`ifndef YSYX_CLINT_MTIME_WR_EN
        bus_wr(32'hBFF8, 32'h0, 4'hF, b, acc);
        check("mtime_ro_bresp", 64'(b), 64'd2);
        bus_rd(32'hBFF8, d, r, acc);
        check("mtime_ro_val", 64'(d), mtime_at(acc) & 64'hFFFF_FFFF);
`endif

        // random traffic against the register model
        for (int i = 0; i < 60; i++) begin
            a     = pool[$urandom_range(0, 15)];
            a16   = a[15:0];
            is_wr = 1'($urandom_range(0, 1));
`ifdef YSYX_CLINT_MTIME_WR_EN
            if (a16 == 16'hBFF8 || a16 == 16'hBFFC) is_wr = 1'b0;
`endif
            wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : 32'($urandom);
            ws = 4'($urandom);
            if (is_wr) begin
                bus_wr(a, wd, ws, b, acc);
                exp_resp = 2'b00;
                case (a16)
                    16'h0000, 16'h0004: if (ws[0]) m_msip[a16[2]] = wd[0];
                    16'h4000, 16'h4004, 16'h4008, 16'h400C: begin
                        half = a16[2] ? m_cmp[a16[3]][63:32] : m_cmp[a16[3]][31:0];
                        for (int bb = 0; bb < 4; bb++)
                            if (ws[bb]) half[8*bb +: 8] = wd[8*bb +: 8];
                        if (a16[2]) m_cmp[a16[3]][63:32] = half;
                        else        m_cmp[a16[3]][31:0]  = half;
                    end
                    default: exp_resp = 2'b10;
                endcase
                check("rnd_bresp", 64'(b), 64'(exp_resp));
            end else begin
                bus_rd(a, d, r, acc);
                exp_resp = 2'b00;
                case (a16)
                    16'h0000, 16'h0004: exp_d = {31'b0, m_msip[a16[2]]};
                    16'h4000, 16'h4004, 16'h4008, 16'h400C:
                        exp_d = a16[2] ? m_cmp[a16[3]][63:32] : m_cmp[a16[3]][31:0];
                    16'hBFF8: exp_d = 32'(mtime_at(acc));
                    16'hBFFC: exp_d = 32'(mtime_at(acc) >> 32);
                    default: begin exp_d = '0; exp_resp = 2'b10; end
                endcase
                check("rnd_rdata", 64'(d), 64'(exp_d));
                check("rnd_rresp", 64'(r), 64'(exp_resp));
            end
        end
        repeat (2) @(negedge clock);
        k = cyc;
        for (int h = 0; h < NH; h++) exp_mtip[h] = (mtime_at(k - 1) >= m_cmp[h]);
        check("rnd_mtip", 64'(mtip), 64'(exp_mtip));
        check("rnd_msip", 64'(msip), 64'(m_msip));

        // reset while a read response is pending
        @(negedge clock);
        araddr = 32'hBFF8; arvalid = 1'b1;
        @(posedge clock); #1;
        arvalid = 1'b0;
        check("pre_rst_rvalid", 64'(rvalid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_rvalid",  64'(rvalid),  64'd0);
        check("midrst_arready", 64'(arready), 64'd1);
        check("midrst_mtip",    64'(mtip),    64'd0);
        check("midrst_msip",    64'(msip),    64'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        m_msip = '0;
        bus_rd(32'hBFF8, d, r, acc);
        check("postrst_mtime", 64'(d), mtime_at(acc) & 64'hFFFF_FFFF);
        bus_rd(32'h400C, d, r, acc);
        check("postrst_cmp1hi", 64'(d), 64'hFFFF_FFFF);
        bus_rd(32'h0004, d, r, acc);
        check("postrst_msip1", 64'(d), 64'd0);

`ifdef YSYX_CLINT_MTIME_WR_EN
        // hi first so no carry can land between the two halves
        bus_wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF, b, acc);
        check("mtime_hi_bresp", 64'(b), 64'd0);
        bus_wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF, b, acc);
        check("mtime_lo_bresp", 64'(b), 64'd0);
        e_cmp = acc + 1;
        bus_rd(32'hBFF8, d, r, acc);
        check("wrap_lo", 64'(d), (64'hFFFF_FFFF_FFFF_FFFF + 64'(acc / P - e_cmp / P)) & 64'hFFFF_FFFF);
        repeat (8) @(posedge clock);
        bus_rd(32'hBFFC, d, r, acc);
        check("wrap_hi", 64'(d), (64'hFFFF_FFFF_FFFF_FFFF + 64'(acc / P - e_cmp / P)) >> 32);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
